// File: rtl/multicycle_pkg.sv
// Shared types and constants for the LEGv8 multicycle sequencing controller:
// state encoding, opcode match patterns, ALU/sign-extend selects and the control word.
package multicycle_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    EXEC   = 4'd2,
    WB_ALU = 4'd3,
    ADDR   = 4'd4,
    MEM_RD = 4'd5,
    MEM_WR = 4'd6,
    WB_MEM = 4'd7,
    BRANCH = 4'd8,
    HALT   = 4'd15
  } state_t;

  localparam logic [10:0] OPC_LDUR   = 11'b11111000010;
  localparam logic [10:0] OPC_STUR   = 11'b11111000000;
  localparam logic [10:0] OPC_ADD    = 11'b10001011000;
  localparam logic [10:0] OPC_SUB    = 11'b11001011000;
  localparam logic [10:0] OPC_AND    = 11'b10001010000;
  localparam logic [10:0] OPC_ORR    = 11'b10101010000;
  localparam logic [10:0] OPC_CBZ    = 11'b10110100000;
  localparam logic [10:0] OPC_B      = 11'b00010100000;
  localparam logic [10:0] OPC_MOVZ   = 11'b11010010100;

  localparam logic [10:0] MASK_EXACT = 11'b11111111111;
  localparam logic [10:0] MASK_CBZ   = 11'b11111111000;
  localparam logic [10:0] MASK_B     = 11'b11111100000;
  localparam logic [10:0] MASK_MOVZ  = 11'b11111111100;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_ORR   = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;

  localparam logic [2:0] SIGN_I    = 3'b000;
  localparam logic [2:0] SIGN_D    = 3'b001;
  localparam logic [2:0] SIGN_B    = 3'b010;
  localparam logic [2:0] SIGN_CB   = 3'b011;
  localparam logic [2:0] SIGN_MOVZ = 3'b100;

  typedef struct packed {
    logic r;
    logic movz;
    logic ldur;
    logic stur;
    logic cbz;
    logic b;
    logic illegal;
  } opclass_t;

  // cbz_sel marks the CBZ branch cycle, where pcsel follows the zero flag
  typedef struct packed {
    logic       irwrite;
    logic       pcwrite;
    logic       pcsel;
    logic       cbz_sel;
    logic       reg2loc;
    logic       alusrc;
    logic       mem2reg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       halted;
    logic [3:0] aluop;
    logic [2:0] signop;
  } ctrl_t;

  function automatic logic opc_match(input logic [10:0] opc,
                                     input logic [10:0] mask,
                                     input logic [10:0] value);
    return ((opc & mask) == value);
  endfunction

  // Moore control word for a state and instruction class
  function automatic ctrl_t decode_ctrl(input state_t st,
                                        input opclass_t cls,
                                        input logic [3:0] r_aluop);
    ctrl_t c;
    c = '0;
    case (st)
      FETCH: begin
        c.irwrite = 1'b1;
      end
      DECODE: begin
        c.reg2loc = cls.stur | cls.cbz;
      end
      EXEC, WB_ALU: begin
        if (cls.movz) begin
          c.alusrc = 1'b1;
          c.aluop  = ALU_PASSB;
          c.signop = SIGN_MOVZ;
        end else begin
          c.aluop  = r_aluop;
        end
        if (st == WB_ALU) begin
          c.regwrite = 1'b1;
          c.pcwrite  = 1'b1;
        end else begin
          c.regwrite = 1'b0;
        end
      end
      ADDR: begin
        c.reg2loc = cls.stur;
        c.alusrc  = 1'b1;
        c.aluop   = ALU_ADD;
        c.signop  = SIGN_D;
      end
      MEM_RD: begin
        c.memread = 1'b1;
      end
      MEM_WR: begin
        c.reg2loc  = 1'b1;
        c.memwrite = 1'b1;
        c.pcwrite  = 1'b1;
      end
      WB_MEM: begin
        c.mem2reg  = 1'b1;
        c.regwrite = 1'b1;
        c.pcwrite  = 1'b1;
      end
      BRANCH: begin
        c.pcwrite = 1'b1;
        c.pcsel   = 1'b1;
        if (cls.cbz) begin
          c.cbz_sel = 1'b1;
          c.reg2loc = 1'b1;
          c.aluop   = ALU_PASSB;
          c.signop  = SIGN_CB;
        end else begin
          c.signop  = SIGN_B;
        end
      end
      HALT: begin
        c.halted = 1'b1;
      end
      default: begin
        c.halted = 1'b1;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_control_opclass_decode.sv
// Combinational opcode classifier: one-hot instruction class plus the ALU
// operation an R-type opcode selects.
module opclass_decode
  import multicycle_pkg::*;
(
  input  logic [10:0] opcode,
  output opclass_t    opclass,
  output logic [3:0]  r_aluop
);

  // Class match; anything outside the supported set is flagged illegal
  always_comb begin
    opclass = '0;
    if (opc_match(opcode, MASK_EXACT, OPC_LDUR)) begin
      opclass.ldur = 1'b1;
    end else if (opc_match(opcode, MASK_EXACT, OPC_STUR)) begin
      opclass.stur = 1'b1;
    end else if (opc_match(opcode, MASK_EXACT, OPC_ADD) ||
                 opc_match(opcode, MASK_EXACT, OPC_SUB) ||
                 opc_match(opcode, MASK_EXACT, OPC_AND) ||
                 opc_match(opcode, MASK_EXACT, OPC_ORR)) begin
      opclass.r = 1'b1;
    end else if (opc_match(opcode, MASK_CBZ, OPC_CBZ)) begin
      opclass.cbz = 1'b1;
    end else if (opc_match(opcode, MASK_B, OPC_B)) begin
      opclass.b = 1'b1;
    end else if (opc_match(opcode, MASK_MOVZ, OPC_MOVZ)) begin
      opclass.movz = 1'b1;
    end else begin
      opclass.illegal = 1'b1;
    end
  end

  // R-type ALU operation select
  always_comb begin
    r_aluop = ALU_AND;
    case (opcode)
      OPC_ADD: r_aluop = ALU_ADD;
      OPC_SUB: r_aluop = ALU_SUB;
      OPC_AND: r_aluop = ALU_AND;
      OPC_ORR: r_aluop = ALU_ORR;
      default: r_aluop = ALU_AND;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle LEGv8 sequencer: steps each instruction through 3-5 states,
// drives registered datapath controls and counts retired instructions.
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             resetl,
  input  logic [10:0]      opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             irwrite,
  output logic             pcwrite,
  output logic             pcsel,
  output logic             reg2loc,
  output logic             alusrc,
  output logic             mem2reg,
  output logic             regwrite,
  output logic             memread,
  output logic             memwrite,
  output logic [3:0]       aluop,
  output logic [2:0]       signop,
  output logic [3:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] instret
);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [10:0]      opc_r;
  logic [10:0]      opc_nxt_s;
  opclass_t         cls_s;
  logic [3:0]       r_aluop_s;
  ctrl_t            ctrl_r;
  ctrl_t            ctrl_nxt_s;
  logic [CNT_W-1:0] instret_r;
  logic             pcwrite_s;
  logic             pcsel_s;

  // The opcode is only live on the bus during FETCH; decode always looks at
  // the value the register will hold next so the control word can be registered.
  assign opc_nxt_s = (state_r == FETCH) ? opcode : opc_r;

  opclass_decode u_opclass_decode (
    .opcode  (opc_nxt_s),
    .opclass (cls_s),
    .r_aluop (r_aluop_s)
  );

  // Next-state sequencing per instruction class
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      FETCH:  state_nxt_s = DECODE;
      DECODE: begin
        if (cls_s.r || cls_s.movz) begin
          state_nxt_s = EXEC;
        end else if (cls_s.ldur || cls_s.stur) begin
          state_nxt_s = ADDR;
        end else if (cls_s.cbz || cls_s.b) begin
          state_nxt_s = BRANCH;
        end else begin
          state_nxt_s = HALT;
        end
      end
      EXEC:   state_nxt_s = WB_ALU;
      WB_ALU: state_nxt_s = FETCH;
      ADDR: begin
        if (cls_s.ldur) begin
          state_nxt_s = MEM_RD;
        end else begin
          state_nxt_s = MEM_WR;
        end
      end
      MEM_RD: state_nxt_s = mem_ready ? WB_MEM : MEM_RD;
      MEM_WR: state_nxt_s = mem_ready ? FETCH : MEM_WR;
      WB_MEM: state_nxt_s = FETCH;
      BRANCH: state_nxt_s = FETCH;
      HALT:   state_nxt_s = HALT;
      default: state_nxt_s = HALT;
    endcase
  end

  assign ctrl_nxt_s = decode_ctrl(state_nxt_s, cls_s, r_aluop_s);

  // A store retires only on the cycle memory accepts it; CBZ always writes the
  // PC, choosing the branch target or PC+4 from the zero flag.
  assign pcwrite_s = ctrl_r.pcwrite & (~ctrl_r.memwrite | mem_ready);
  assign pcsel_s   = ctrl_r.cbz_sel ? zero : ctrl_r.pcsel;

  // State, captured opcode, control word and retire counter
  always_ff @(posedge CLK) begin
    if (!resetl) begin
      state_r   <= FETCH;
      opc_r     <= 11'b00000000000;
      ctrl_r    <= decode_ctrl(FETCH, '0, ALU_AND);
      instret_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      opc_r   <= opc_nxt_s;
      ctrl_r  <= ctrl_nxt_s;
      if (pcwrite_s) begin
        instret_r <= instret_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        instret_r <= instret_r;
      end
    end
  end

  assign irwrite  = ctrl_r.irwrite;
  assign pcwrite  = pcwrite_s;
  assign pcsel    = pcsel_s;
  assign reg2loc  = ctrl_r.reg2loc;
  assign alusrc   = ctrl_r.alusrc;
  assign mem2reg  = ctrl_r.mem2reg;
  assign regwrite = ctrl_r.regwrite;
  assign memread  = ctrl_r.memread;
  assign memwrite = ctrl_r.memwrite;
  assign aluop    = ctrl_r.aluop;
  assign signop   = ctrl_r.signop;
  assign halted   = ctrl_r.halted;
  assign state    = state_r;
  assign instret  = instret_r;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control; a second 4-bit-counter
// instance exercises retire-counter wrap with back-to-back branches.
module tb_multicycle_control;

  logic        CLK = 1'b0;
  logic        resetl, zero, mem_ready;
  logic [10:0] opcode;
  logic        irwrite, pcwrite, pcsel, reg2loc, alusrc, mem2reg, regwrite, memread, memwrite, halted;
  logic [3:0]  aluop, state;
  logic [2:0]  signop;
  logic [31:0] instret;

  logic        resetl4, zero4, mem_ready4;
  logic [10:0] opcode4;
  logic        irwrite4, pcwrite4, pcsel4, reg2loc4, alusrc4, mem2reg4, regwrite4, memread4, memwrite4, halted4;
  logic [3:0]  aluop4, state4;
  logic [2:0]  signop4;
  logic [3:0]  instret4;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  multicycle_control #(.CNT_W(32)) dut (
    .CLK(CLK), .resetl(resetl), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .irwrite(irwrite), .pcwrite(pcwrite), .pcsel(pcsel), .reg2loc(reg2loc), .alusrc(alusrc),
    .mem2reg(mem2reg), .regwrite(regwrite), .memread(memread), .memwrite(memwrite),
    .aluop(aluop), .signop(signop), .state(state), .halted(halted), .instret(instret)
  );

  multicycle_control #(.CNT_W(4)) dut4 (
    .CLK(CLK), .resetl(resetl4), .opcode(opcode4), .zero(zero4), .mem_ready(mem_ready4),
    .irwrite(irwrite4), .pcwrite(pcwrite4), .pcsel(pcsel4), .reg2loc(reg2loc4), .alusrc(alusrc4),
    .mem2reg(mem2reg4), .regwrite(regwrite4), .memread(memread4), .memwrite(memwrite4),
    .aluop(aluop4), .signop(signop4), .state(state4), .halted(halted4), .instret(instret4)
  );

  // Two reset edges; returns at the negedge of the first FETCH cycle
  task automatic do_reset;
    resetl = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    resetl = 1'b1;
  endtask

  task automatic test_reset;
    opcode = 11'b10001011000;
    do_reset();
    checks++;
    if (state !== 4'd0 || irwrite !== 1'b1 || halted !== 1'b0 || instret !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: got state=%0d irwrite=%b halted=%b instret=%0d, want 0 1 0 0",
               state, irwrite, halted, instret);
    end
    checks++;
    if ({pcwrite, regwrite, memread, memwrite, mem2reg} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_enables: got %b want 00000", {pcwrite, regwrite, memread, memwrite, mem2reg});
    end
  endtask

  task automatic test_add;
    logic [3:0] exp_st [4];
    exp_st = '{4'd0, 4'd1, 4'd2, 4'd3};
    opcode = 11'b10001011000;
    mem_ready = 1'b1;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (state !== exp_st[c] || regwrite !== (c == 3) || pcwrite !== (c == 3)) begin
        errors++;
        $display("FAIL add_cycle%0d: got state=%0d regwrite=%b pcwrite=%b, want %0d %b %b",
                 c + 1, state, regwrite, pcwrite, exp_st[c], (c == 3), (c == 3));
      end
      if (c == 2) begin
        checks++;
        if (aluop !== 4'b0010 || alusrc !== 1'b0) begin
          errors++;
          $display("FAIL add_exec_alu: got aluop=%b alusrc=%b want 0010 0", aluop, alusrc);
        end
      end
      if (c == 3) begin
        checks++;
        if (pcsel !== 1'b0 || instret !== 32'd0) begin
          errors++;
          $display("FAIL add_wb: got pcsel=%b instret=%0d want 0 0", pcsel, instret);
        end
      end
      @(negedge CLK);
    end
    checks++;
    if (state !== 4'd0 || instret !== 32'd1) begin
      errors++;
      $display("FAIL add_retire: got state=%0d instret=%0d want 0 1", state, instret);
    end
  endtask

  task automatic test_movz;
    opcode = 11'b11010010101;
    do_reset();
    @(negedge CLK);
    @(negedge CLK);
    checks++;
    if (state !== 4'd2 || alusrc !== 1'b1 || aluop !== 4'b0111 || signop !== 3'b100) begin
      errors++;
      $display("FAIL movz_exec: got state=%0d alusrc=%b aluop=%b signop=%b want 2 1 0111 100",
               state, alusrc, aluop, signop);
    end
    @(negedge CLK);
    checks++;
    if (state !== 4'd3 || regwrite !== 1'b1 || pcwrite !== 1'b1) begin
      errors++;
      $display("FAIL movz_wb: got state=%0d regwrite=%b pcwrite=%b want 3 1 1", state, regwrite, pcwrite);
    end
  endtask

  task automatic test_ldur_wait;
    logic [3:0] exp_st [8];
    int rd_cycles = 0;
    int pc_pulses = 0;
    exp_st = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd5, 4'd5, 4'd5, 4'd7};
    opcode = 11'b11111000010;
    mem_ready = 1'b0;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      checks++;
      if (state !== exp_st[c]) begin
        errors++;
        $display("FAIL ldur_state_c%0d: got %0d want %0d", c + 1, state, exp_st[c]);
      end
      if (memread) rd_cycles++;
      if (pcwrite) pc_pulses++;
      if (c == 7) begin
        checks++;
        if (mem2reg !== 1'b1 || regwrite !== 1'b1 || pcwrite !== 1'b1 || pcsel !== 1'b0) begin
          errors++;
          $display("FAIL ldur_wb_mem: got mem2reg=%b regwrite=%b pcwrite=%b pcsel=%b want 1 1 1 0",
                   mem2reg, regwrite, pcwrite, pcsel);
        end
      end
      if (c == 6) mem_ready = 1'b1;
      @(negedge CLK);
    end
    checks++;
    if (rd_cycles != 4 || pc_pulses != 1 || state !== 4'd0 || instret !== 32'd1) begin
      errors++;
      $display("FAIL ldur_totals: got memread_cycles=%0d pcwrite_pulses=%0d state=%0d instret=%0d want 4 1 0 1",
               rd_cycles, pc_pulses, state, instret);
    end
  endtask

  task automatic test_stur;
    opcode = 11'b11111000000;
    mem_ready = 1'b1;
    do_reset();
    repeat (3) @(negedge CLK);
    checks++;
    if (state !== 4'd6 || memwrite !== 1'b1 || pcwrite !== 1'b1 || pcsel !== 1'b0 || reg2loc !== 1'b1) begin
      errors++;
      $display("FAIL stur_mem_wr: got state=%0d memwrite=%b pcwrite=%b pcsel=%b reg2loc=%b want 6 1 1 0 1",
               state, memwrite, pcwrite, pcsel, reg2loc);
    end
    @(negedge CLK);
    checks++;
    if (state !== 4'd0 || memwrite !== 1'b0 || instret !== 32'd1) begin
      errors++;
      $display("FAIL stur_retire: got state=%0d memwrite=%b instret=%0d want 0 0 1", state, memwrite, instret);
    end
  endtask

  task automatic test_cbz(input logic zv);
    logic bad_en = 1'b0;
    opcode = 11'b10110100011;
    zero = zv;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      if (regwrite || memwrite) bad_en = 1'b1;
      if (c == 2) begin
        checks++;
        if (state !== 4'd8 || pcwrite !== 1'b1 || pcsel !== zv || reg2loc !== 1'b1 ||
            signop !== 3'b011 || alusrc !== 1'b0 || aluop !== 4'b0111) begin
          errors++;
          $display("FAIL cbz_branch_z%b: got state=%0d pcwrite=%b pcsel=%b reg2loc=%b signop=%b alusrc=%b aluop=%b want 8 1 %b 1 011 0 0111",
                   zv, state, pcwrite, pcsel, reg2loc, signop, alusrc, aluop, zv);
        end
      end
      @(negedge CLK);
    end
    checks++;
    if (bad_en !== 1'b0 || state !== 4'd0 || instret !== 32'd1) begin
      errors++;
      $display("FAIL cbz_retire_z%b: got stray_enable=%b state=%0d instret=%0d want 0 0 1", zv, bad_en, state, instret);
    end
    zero = 1'b0;
  endtask

  task automatic test_illegal_halt;
    int bad_cycles = 0;
    opcode = 11'b10001011000;
    mem_ready = 1'b1;
    do_reset();
    repeat (3) @(negedge CLK);
    opcode = 11'b00000000000;
    @(negedge CLK);
    @(negedge CLK);
    checks++;
    if (state !== 4'd1) begin
      errors++;
      $display("FAIL illegal_decode: got state=%0d want 1", state);
    end
    @(negedge CLK);
    checks++;
    if (state !== 4'd15 || halted !== 1'b1) begin
      errors++;
      $display("FAIL illegal_halt: got state=%0d halted=%b want 15 1", state, halted);
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if ({irwrite, pcwrite, regwrite, memread, memwrite, mem2reg} !== 6'b000000 ||
          instret !== 32'd1 || state !== 4'd15) bad_cycles++;
    end
    checks++;
    if (bad_cycles != 0) begin
      errors++;
      $display("FAIL halt_hold: got %0d bad cycles want 0 (instret=%0d)", bad_cycles, instret);
    end
    resetl = 1'b0;
    @(negedge CLK);
    resetl = 1'b1;
    checks++;
    if (state !== 4'd0 || halted !== 1'b0 || irwrite !== 1'b1 || instret !== 32'd0) begin
      errors++;
      $display("FAIL halt_exit: got state=%0d halted=%b irwrite=%b instret=%0d want 0 0 1 0",
               state, halted, irwrite, instret);
    end
  endtask

  task automatic test_reset_mid;
    opcode = 11'b11111000000;
    mem_ready = 1'b0;
    do_reset();
    repeat (3) @(negedge CLK);
    checks++;
    if (state !== 4'd6 || memwrite !== 1'b1 || pcwrite !== 1'b0) begin
      errors++;
      $display("FAIL mid_mem_wr: got state=%0d memwrite=%b pcwrite=%b want 6 1 0", state, memwrite, pcwrite);
    end
    resetl = 1'b0;
    @(negedge CLK);
    checks++;
    if (memwrite !== 1'b0 || state !== 4'd0 || instret !== 32'd0 || pcwrite !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got memwrite=%b state=%0d instret=%0d pcwrite=%b want 0 0 0 0",
               memwrite, state, instret, pcwrite);
    end
    resetl = 1'b1;
    mem_ready = 1'b1;
  endtask

  task automatic test_back_to_back;
    logic [3:0] cnt = 4'd0;
    logic [3:0] exp_st;
    int pulses = 0;
    logic saw15 = 1'b0;
    resetl4 = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    resetl4 = 1'b1;
    for (int c = 0; c < 48; c++) begin
      exp_st = (c % 3 == 0) ? 4'd0 : ((c % 3 == 1) ? 4'd1 : 4'd8);
      checks++;
      if (instret4 !== cnt || state4 !== exp_st || pcwrite4 !== (c % 3 == 2) || irwrite4 !== (c % 3 == 0)) begin
        errors++;
        $display("FAIL b2b_c%0d: got instret=%0d state=%0d pcwrite=%b irwrite=%b want %0d %0d %b %b",
                 c, instret4, state4, pcwrite4, irwrite4, cnt, exp_st, (c % 3 == 2), (c % 3 == 0));
      end
      if (c % 3 == 2) begin
        checks++;
        if (pcsel4 !== 1'b1 || signop4 !== 3'b010 || {reg2loc4, alusrc4, mem2reg4, regwrite4,
            memread4, memwrite4, halted4} !== 7'b0000000 || aluop4 !== 4'b0000) begin
          errors++;
          $display("FAIL b2b_branch_c%0d: got pcsel=%b signop=%b others=%b aluop=%b want 1 010 0000000 0000",
                   c, pcsel4, signop4, {reg2loc4, alusrc4, mem2reg4, regwrite4, memread4, memwrite4, halted4}, aluop4);
        end
      end
      if (pcwrite4) begin
        pulses++;
        if (instret4 === 4'd15) saw15 = 1'b1;
        cnt = cnt + 4'd1;
      end
      @(negedge CLK);
    end
    checks++;
    if (pulses != 16 || instret4 !== 4'd0 || saw15 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_wrap: got pulses=%0d instret=%0d saw15=%b want 16 0 1", pulses, instret4, saw15);
    end
  endtask

  initial begin
    resetl = 1'b0;
    opcode = 11'b00000000000;
    zero = 1'b0;
    mem_ready = 1'b1;
    resetl4 = 1'b0;
    opcode4 = 11'b00010100111;
    zero4 = 1'b0;
    mem_ready4 = 1'b1;
    test_reset();
    test_add();
    test_movz();
    test_ldur_wait();
    test_stur();
    test_cbz(1'b1);
    test_cbz(1'b0);
    test_illegal_halt();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
